// File: rtl/instr_encode_loader.sv
// Packs abstract instruction descriptors into RV32I words and streams them into instruction memory.
// Optional NOP padding of the remaining memory after finish is enabled by defining NOP_PAD_EN.
module instr_encode_loader #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [2:0]        in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic [ADDR_W-2:0] word_count,
    output logic              illegal,
    output logic              done,
    output logic [1:0]        state_dbg
);

    // Handshake: a descriptor transfers on any rising edge where in_valid && in_ready;
    // in_valid may be held high for back-to-back transfers, in_ready is high only in RUN
    // until the last word address has been accepted.

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((DEPTH_WORDS - 1) * 4);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);
    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                full, full_n;
    logic                wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [31:0]         wr_data_n;
    logic [ADDR_W-2:0]   wc_n;
    logic                illegal_n;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alu_ok;
    logic        imm12_ok, imm13_ok, imm21_ok;
    logic        accept;

    assign in_ready  = (state == S_RUN) && !full;
    assign accept    = in_valid && in_ready;
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    assign imm12_ok = (in_imm[31:11] == {21{in_imm[11]}});
    assign imm13_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
    assign imm21_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];

    always_comb begin
        f3     = 3'b000;
        f7     = 7'b0000000;
        alu_ok = 1'b1;
        case (in_alu_op)
            3'b000:  f3 = 3'b000;
            3'b001:  f7 = 7'b0100000;
            3'b010:  f3 = 3'b111;
            3'b011:  f3 = 3'b110;
            3'b100:  f3 = 3'b010;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (in_type)
            3'b000: begin
                enc_ok   = alu_ok;
                enc_word = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            end
            3'b001: begin
                // There is no subi; negative addi is the only way to subtract an immediate.
                enc_ok   = alu_ok && (in_alu_op != 3'b001) && imm12_ok;
                enc_word = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
            end
            3'b010: begin
                enc_ok   = imm12_ok;
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            3'b011: begin
                enc_ok   = imm12_ok;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            3'b101: begin
                enc_ok   = imm13_ok;
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            end
            3'b110: begin
                enc_ok   = imm21_ok;
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        full_n    = full;
        wr_en_n   = 1'b0;
        wr_addr_n = imem_addr;
        wr_data_n = imem_wr_data;
        wc_n      = word_count;
        illegal_n = illegal;
        if (start) begin
            // A descriptor accepted alongside start belongs to the abandoned session and is dropped.
            state_n   = S_RUN;
            addr_n    = {base_addr[ADDR_W-1:2], 2'b00};
            full_n    = 1'b0;
            wc_n      = '0;
            illegal_n = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (accept) begin
                        if (enc_ok) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = addr;
                            wr_data_n = enc_word;
                            wc_n      = word_count + 1'b1;
                            addr_n    = addr + STEP;
                            full_n    = (addr == LAST_ADDR);
                        end else begin
                            illegal_n = 1'b1;
                        end
                    end
                    if (full) begin
                        state_n = S_DONE;
                    end else if (finish) begin
`ifdef NOP_PAD_EN
                        state_n = full_n ? S_DONE : S_PAD;
`else
                        state_n = S_DONE;
`endif
                    end
                end
`ifdef NOP_PAD_EN
                S_PAD: begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr;
                    wr_data_n = NOP_WORD;
                    wc_n      = word_count + 1'b1;
                    addr_n    = addr + STEP;
                    if (addr == LAST_ADDR) begin
                        full_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr         <= '0;
            full         <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_wr_data <= '0;
            word_count   <= '0;
            illegal      <= 1'b0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            full         <= full_n;
            imem_wr_en   <= wr_en_n;
            imem_addr    <= wr_addr_n;
            imem_wr_data <= wr_data_n;
            word_count   <= wc_n;
            illegal      <= illegal_n;
        end
    end

endmodule
